// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg
//   Shared definitions for the RAM loader and the RAM it fills: default
//   word/address widths and the loader state encoding.
package ram_loader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if
//   Bundles the host byte stream, RAM write/read ports and status flags of
//   the RAM loader.
//   master : loader side (consumes host stream, drives RAM and status)
//   slave  : host / RAM side
//   Signals: start, in_data, in_valid, in_ready, wr_en, wr_addr, wr_data,
//            rd_en, rd_addr, rd_data, busy, done, error.
interface ram_loader_if #(
  parameter int DATA_W = ram_loader_pkg::DATA_W_DEF,
  parameter int ADDR_W = ram_loader_pkg::ADDR_W_DEF
);
  import ram_loader_pkg::*;

  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, in_data, in_valid, rd_data,
    output in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, done, error
  );

  modport slave (
    output start, in_data, in_valid, rd_data,
    input  in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, done, error
  );

endinterface

// File: rtl/ram_loader.sv
// ram_loader
//   Streams 2**ADDR_W host bytes into a RAM, reads the whole RAM back and
//   compares a modular checksum of what was written against what was read.
//   Ports:
//     clk  - system clock, rising edge
//     res  - synchronous active-high reset
//     bus  - ram_loader_if.master: host stream (start/in_*), RAM write port
//            (wr_*), RAM read port (rd_*, one-cycle read latency), status
//            (busy/done/error)
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          res,
  ram_loader_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] wr_sum_q, wr_sum_d;
  logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_pend_q, rd_pend_d;
  logic              hs;
  logic              rd_fire;

  // Checksum accumulate, wrapping modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] val);
    return acc + val;
  endfunction

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_sum_d  = wr_sum_q;
    rd_sum_d  = rd_sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    hs = bus.in_valid && (state_q == ST_LOAD);
    // The first VERIFY cycle still carries the final write strobe; reads
    // start only once it has gone, so read and write never overlap.
    rd_fire   = (state_q == ST_VERIFY) && !wr_en_q;
    rd_pend_d = rd_fire;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.start) begin
          state_d  = ST_LOAD;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          wr_sum_d = '0;
          rd_sum_d = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_cnt_q;
          wr_data_d = bus.in_data;
          wr_cnt_d  = wr_cnt_q + ADDR_ONE;
          wr_sum_d  = csum_add(wr_sum_q, bus.in_data);
          if (wr_cnt_q == LAST_ADDR) state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (rd_fire) begin
          rd_cnt_d = rd_cnt_q + ADDR_ONE;
          if (rd_cnt_q == LAST_ADDR) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // First CHECK cycle folds in the last read word; the compare waits
        // until that accumulation has landed in rd_sum_q.
        if (!rd_pend_q) begin
          state_d = (wr_sum_q == rd_sum_q) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read data returns one cycle after its strobe.
    if (rd_pend_q) rd_sum_d = csum_add(rd_sum_q, bus.rd_data);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_sum_q  <= wr_sum_d;
      rd_sum_q  <= rd_sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign bus.in_ready = (state_q == ST_LOAD);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_en    = rd_fire;
  assign bus.rd_addr  = rd_cnt_q;
  assign bus.busy     = (state_q == ST_LOAD) || (state_q == ST_VERIFY) ||
                        (state_q == ST_CHECK);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.error    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader
//   Directed bench for ram_loader with a behavioural RAM (registered read,
//   optional corruption of address 7) and a write scoreboard.
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic clk;
  logic res;
  logic corrupt;

  ram_loader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  ram_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];

  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    if (bus.rd_en) begin
      if (corrupt && bus.rd_addr == 4'd7) bus.rd_data <= mem[bus.rd_addr] + 8'd1;
      else                                bus.rd_data <= mem[bus.rd_addr];
    end
  end

  int          total  = 0;
  int          passed = 0;
  int          acc    = 0;
  int          cyc    = 0;
  logic [3:0]  rd_exp = 4'd0;
  logic [11:0] wq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: record a handshake about to happen, then check strobes.
  task automatic tick();
    logic [11:0] e;
    if (bus.in_valid && bus.in_ready && !res) begin
      wq.push_back({4'(acc), bus.in_data});
      acc++;
    end
    @(negedge clk);
    if (bus.wr_en) begin
      if (wq.size() == 0) begin
        chk("wr_extra", 32'(bus.wr_en), 32'd0);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e[11:8]));
        chk("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
      end
      chk("wr_rd_excl", 32'(bus.rd_en), 32'd0);
    end
    if (bus.rd_en) begin
      chk("rd_addr", 32'(bus.rd_addr), 32'(rd_exp));
      rd_exp = rd_exp + 4'd1;
    end
  endtask

  task automatic run_load(input bit toggle, input bit poke, input bit stop_at5);
    acc    = 0;
    rd_exp = 4'd0;
    cyc    = 0;
    bus.start = 1'b1;
    tick();
    cyc++;
    bus.start = 1'b0;
    chk("ld_busy",     32'(bus.busy),     32'd1);
    chk("ld_done_clr", 32'(bus.done),     32'd0);
    chk("ld_err_clr",  32'(bus.error),    32'd0);
    chk("ld_ready",    32'(bus.in_ready), 32'd1);
    while (!bus.done && !bus.error && cyc < 120) begin
      if (stop_at5 && acc == 5) break;
      bus.in_valid = toggle ? cyc[0] : 1'b1;
      bus.in_data  = (acc < 16) ? 8'(acc + 1) : 8'hAA;
      bus.start    = poke && (cyc == 5 || cyc == 20 || cyc == 34);
      tick();
      cyc++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    res          = 1'b1;
    corrupt      = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("rst_rd_en",    32'(bus.rd_en),    32'd0);
    chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("rst_rd_addr",  32'(bus.rd_addr),  32'd0);
    chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_error",    32'(bus.error),    32'd0);
    res = 1'b0;
    tick();
    chk("idle_start_ignored_ready", 32'(bus.in_ready), 32'd0);

    // Back-to-back 0x01..0x10, in_valid held high afterwards
    run_load(1'b0, 1'b0, 1'b0);
    chk("r1_cycles",   32'(cyc),          32'd36);
    chk("r1_done",     32'(bus.done),     32'd1);
    chk("r1_error",    32'(bus.error),    32'd0);
    chk("r1_busy",     32'(bus.busy),     32'd0);
    chk("r1_accepted", 32'(acc),          32'd16);
    chk("r1_sb_empty", 32'(wq.size()),    32'd0);
    chk("r1_wr_sum",   32'(dut.wr_sum_q), 32'h88);
    chk("r1_rd_sum",   32'(dut.rd_sum_q), 32'h88);
    repeat (3) tick();
    chk("r1_done_hold", 32'(bus.done), 32'd1);

    // Restart from DONE, start pulsed in LOAD, VERIFY and CHECK
    run_load(1'b0, 1'b1, 1'b0);
    chk("r2_cycles",   32'(cyc),       32'd36);
    chk("r2_done",     32'(bus.done),  32'd1);
    chk("r2_accepted", 32'(acc),       32'd16);
    chk("r2_sb_empty", 32'(wq.size()), 32'd0);

    // in_valid toggling every cycle
    run_load(1'b1, 1'b0, 1'b0);
    chk("r3_done",     32'(bus.done),  32'd1);
    chk("r3_error",    32'(bus.error), 32'd0);
    chk("r3_accepted", 32'(acc),       32'd16);
    chk("r3_sb_empty", 32'(wq.size()), 32'd0);
    chk("r3_rd_count", 32'(rd_exp),    32'd0);

    // RAM returns 0x09 instead of 0x08 at address 7
    corrupt = 1'b1;
    run_load(1'b0, 1'b0, 1'b0);
    chk("r4_error",  32'(bus.error), 32'd1);
    chk("r4_done",   32'(bus.done),  32'd0);
    chk("r4_cycles", 32'(cyc),       32'd36);
    chk("r4_rd_sum", 32'(dut.rd_sum_q), 32'h89);
    corrupt = 1'b0;
    repeat (3) tick();
    chk("r4_error_hold", 32'(bus.error), 32'd1);

    // Reset right after the fifth handshake
    run_load(1'b0, 1'b0, 1'b1);
    chk("r5_accepted", 32'(acc), 32'd5);
    res = 1'b1;
    tick();
    chk("r5_in_ready", 32'(bus.in_ready), 32'd0);
    chk("r5_wr_en",    32'(bus.wr_en),    32'd0);
    chk("r5_rd_en",    32'(bus.rd_en),    32'd0);
    chk("r5_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("r5_wr_data",  32'(bus.wr_data),  32'd0);
    chk("r5_rd_addr",  32'(bus.rd_addr),  32'd0);
    chk("r5_busy",     32'(bus.busy),     32'd0);
    chk("r5_done",     32'(bus.done),     32'd0);
    chk("r5_error",    32'(bus.error),    32'd0);
    res = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("r5_idle_ready", 32'(bus.in_ready), 32'd0);
    chk("r5_sb_empty",   32'(wq.size()),    32'd0);

    // Recovery from IDLE
    run_load(1'b0, 1'b0, 1'b0);
    chk("r6_cycles", 32'(cyc),      32'd36);
    chk("r6_done",   32'(bus.done), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter DATA_W, default 8, memory word width in bits.
REQ-002 Parameter ADDR_W, default 4, memory address width; depth = 2**ADDR_W (16).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 res  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a load; sampled in IDLE, DONE, ERROR only.
REQ-006 in_data  input  DATA_W  byte offered by the host.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 wr_en  output  1  RAM write strobe.
REQ-010 wr_addr  output  ADDR_W  RAM write address.
REQ-011 wr_data  output  DATA_W  RAM write data.
REQ-012 rd_en  output  1  RAM read strobe.
REQ-013 rd_addr  output  ADDR_W  RAM read address.
REQ-014 rd_data  input  DATA_W  RAM read data, valid exactly one cycle after rd_en.
REQ-015 busy  output  1  high in LOAD, VERIFY, CHECK.
REQ-016 done  output  1  high in DONE.
REQ-017 error  output  1  high in ERROR.

Function
REQ-018 States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + start -> LOAD; write counter, read counter, both checksums cleared to 0.
REQ-020 start in LOAD/VERIFY/CHECK ignored.
REQ-021 in_ready = 1 only in LOAD; combinational from state.
REQ-022 Handshake = in_valid & in_ready; in_data captured; next cycle wr_en=1, wr_addr=write counter, wr_data=captured byte; otherwise wr_en=0, wr_addr/wr_data hold.
REQ-023 Each handshake: write counter +1 (wraps mod depth), write checksum += in_data mod 2**DATA_W.
REQ-024 Handshake with write counter = depth-1 -> VERIFY; in_ready low from next cycle; no 17th byte accepted.
REQ-025 in_valid low in LOAD: wait indefinitely, no timeout, no writes.
REQ-026 VERIFY first cycle: no rd_en (final wr_en completes); then rd_en=1 on depth consecutive cycles, rd_addr 0..depth-1.
REQ-027 Read checksum += rd_data the cycle after each rd_en, mod 2**DATA_W.
REQ-028 Cycle after last rd_en -> CHECK; CHECK accumulates last rd_data, then one cycle later compares: equal -> DONE, else ERROR.
REQ-029 wr_en and rd_en never asserted together.
REQ-030 DONE and ERROR held until start or res.
REQ-031 Latency, start to done: 1 + 16 handshake cycles (min) + 1 + 16 + 2 cycles.

Reset
REQ-032 res in any state -> IDLE next edge, overriding start.
REQ-033 Reset values: in_ready=0, wr_en=0, rd_en=0, wr_addr=0, rd_addr=0, wr_data=0, busy=0, done=0, error=0; counters, checksums 0.
REQ-034 res mid-LOAD/VERIFY: pending wr_en dropped, no further RAM access; partial contents undefined.

Structure
REQ-035 Shared package holds state enum encoding and DATA_W/ADDR_W defaults shared with ram.
REQ-036 Single module; no sub-module; checksum adders inline.

Verification
REQ-037 start, stream 0x01..0x10 back-to-back, RAM model echoes writes -> 16 wr_en at addr 0..15, checksum 0x88, done=1 after 36 cycles.
REQ-038 in_valid toggling 1/0 every cycle, same data -> 16 writes, correct order, done=1, no extra wr_en.
REQ-039 RAM model corrupts addr 7 (0x08 read as 0x09) -> error=1, done=0.
REQ-040 res asserted after 5th handshake -> next cycle IDLE, wr_en=0, in_ready=0, all outputs reset values.
REQ-041 start pulsed during LOAD and VERIFY -> ignored, sequence unchanged; start in DONE -> new load, done cleared.
REQ-042 in_valid held high after 16th byte -> in_ready=0, only 16 bytes consumed.
